param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 17, data word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 3, log2 of entry count (2**FIFO_DEPTH entries, i.e. 8).
REQ-003 Parameter FWFT_MODE, default 0: 0 = standard registered read; 1 = first-word-fall-through.
REQ-004 Parameter AFULL_THRESH, default 2**FIFO_DEPTH-1, fill level at which isAlmostFull asserts.
REQ-005 Parameter AEMPTY_THRESH, default 1, fill level at or below which isAlmostEmpty asserts.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rstN  input  1  reset; asynchronous, active-low.
REQ-008 writeEn  input  1  push request.
REQ-009 dataIn  input  FIFO_WIDTH  push data.
REQ-010 readEn  input  1  pop request (FWFT: acknowledge of head word).
REQ-011 clearErr  input  1  clears sticky error flags.
REQ-012 dataOut  output  FIFO_WIDTH  read data.
REQ-013 dataValid  output  1  dataOut holds a valid popped/head word.
REQ-014 fillCount  output  FIFO_DEPTH+1  entries currently stored, 0..2**FIFO_DEPTH.
REQ-015 isEmpty, isFull, isAlmostEmpty, isAlmostFull  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 pushAccept = writeEn & !isFull; popAccept = readEn & !isEmpty; both evaluated on pre-edge state.
REQ-018 On pushAccept, dataIn written at write pointer; write pointer increments modulo 2**FIFO_DEPTH.
REQ-019 On popAccept, read pointer increments modulo 2**FIFO_DEPTH; pointers wrap without extra logic or gaps.
REQ-020 fillCount: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 Simultaneous push and pop when neither full nor empty: both accepted, fillCount unchanged.
REQ-022 Push when full is dropped even if pop occurs same cycle; pop when empty is dropped even if push occurs same cycle.
REQ-023 isEmpty = (fillCount==0); isFull = (fillCount==2**FIFO_DEPTH); combinational from registered fillCount.
REQ-024 isAlmostFull = (fillCount >= AFULL_THRESH); isAlmostEmpty = (fillCount <= AEMPTY_THRESH).
REQ-025 FWFT_MODE=0: dataOut registered, updated to popped word on the edge of popAccept; dataValid high exactly one cycle after each popAccept; dataOut holds last value otherwise.
REQ-026 FWFT_MODE=1: dataOut = memory[readPtr] with zero latency; dataValid = !isEmpty; readEn while dataValid consumes the word and next word appears next cycle.
REQ-027 FWFT_MODE=1: a word pushed into an empty FIFO appears on dataOut with dataValid high in the cycle after the push edge.
REQ-028 overflow set on writeEn & isFull; underflow set on readEn & isEmpty; both stay set until clearErr.
REQ-029 clearErr clears both flags next edge; a set condition in the same cycle wins over clear.
REQ-030 Storage array not reset; contents after reset are don't-care and never visible while dataValid low.

Reset
REQ-031 rstN low asynchronously clears pointers, fillCount, dataValid, overflow, underflow to 0; dataOut to 0.
REQ-032 During reset isEmpty=1, isAlmostEmpty=1, isFull=0, isAlmostFull=0.
REQ-033 Reset mid-operation discards all stored words; no push or pop accepted while rstN low; first accept on first rising edge after rstN high.

Verification
REQ-034 Defaults, mode 0: push 8 words 0x00001..0x00008 -> isFull=1, fillCount=8, isAlmostFull=1 from count 7; 9th push -> overflow=1, fillCount stays 8.
REQ-035 Mode 0: pop 8 words -> dataOut 0x00001..0x00008 in order, each with dataValid one cycle after readEn; 9th pop -> underflow=1, dataValid=0.
REQ-036 Fill to 4, assert writeEn and readEn together for 20 cycles -> fillCount stays 4, order preserved across pointer wrap.
REQ-037 Full FIFO, writeEn=readEn=1 one cycle -> pop accepted, push dropped, fillCount=7, overflow=1; clearErr next cycle -> overflow=0.
REQ-038 FWFT_MODE=1: push 0x1ABCD into empty FIFO -> next cycle dataOut=0x1ABCD, dataValid=1 with readEn low; readEn one cycle -> dataValid=0, isEmpty=1.
REQ-039 Fill to 5, drop rstN mid-cycle -> fillCount=0, isEmpty=1, dataValid=0 immediately without clock edge.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty levels and sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int unsigned FIFO_WIDTH    = 17,
  parameter int unsigned FIFO_DEPTH    = 3,
  parameter int unsigned FWFT_MODE     = 0,
  parameter int unsigned AFULL_THRESH  = 2**FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  writeEn,
  input  logic [FIFO_WIDTH-1:0] dataIn,
  input  logic                  readEn,
  input  logic                  clearErr,
  output logic [FIFO_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic [FIFO_DEPTH:0]   fillCount,
  output logic                  isEmpty,
  output logic                  isFull,
  output logic                  isAlmostEmpty,
  output logic                  isAlmostFull,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned ENTRIES = 2**FIFO_DEPTH;
  localparam int unsigned CW      = FIFO_DEPTH + 1;
  localparam logic [FIFO_DEPTH:0] FULL_LVL   = CW'(ENTRIES);
  localparam logic [FIFO_DEPTH:0] AFULL_LVL  = CW'(AFULL_THRESH);
  localparam logic [FIFO_DEPTH:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0] r_mem [ENTRIES];
  logic [FIFO_DEPTH-1:0] r_wr_ptr;
  logic [FIFO_DEPTH-1:0] r_rd_ptr;
  logic [FIFO_DEPTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LVL);
  assign w_push  = writeEn & ~w_full;
  assign w_pop   = readEn & ~w_empty;

  // Storage deliberately has no reset; writes are blocked while rstN is low.
  always_ff @(posedge clk) begin
    if (w_push && rstN) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error condition takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (writeEn & w_full)  | (r_overflow  & ~clearErr);
      r_underflow <= (readEn  & w_empty) | (r_underflow & ~clearErr);
    end
  end

  generate
    if (FWFT_MODE == 0) begin : g_std
      logic [FIFO_WIDTH-1:0] r_dout;
      logic                  r_valid;

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_pop;
          if (w_pop) r_dout <= r_mem[r_rd_ptr];
        end
      end

      assign dataOut   = r_dout;
      assign dataValid = r_valid;
    end else begin : g_fwft
      // Head word is presented combinationally; masked so stale storage never shows.
      assign dataValid = ~w_empty;
      assign dataOut   = w_empty ? '0 : r_mem[r_rd_ptr];
    end
  endgenerate

  assign fillCount     = r_count;
  assign isEmpty       = w_empty;
  assign isFull        = w_full;
  assign isAlmostFull  = (r_count >= AFULL_LVL);
  assign isAlmostEmpty = (r_count <= AEMPTY_LVL);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench: one standard-read instance and one FWFT instance.
module tb_param_sync_fifo;

  localparam int unsigned W = 17;
  localparam int unsigned D = 3;

  logic clk = 1'b0;
  logic rstN;

  logic         wr0, rd0, clr0;
  logic [W-1:0] din0;
  logic [W-1:0] dout0;
  logic         val0, emp0, full0, ae0, af0, ovf0, unf0;
  logic [D:0]   cnt0;

  logic         wr1, rd1, clr1;
  logic [W-1:0] din1;
  logic [W-1:0] dout1;
  logic         val1, emp1, full1, ae1, af1, ovf1, unf1;
  logic [D:0]   cnt1;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT_MODE(0)) u0 (
    .clk(clk), .rstN(rstN), .writeEn(wr0), .dataIn(din0), .readEn(rd0), .clearErr(clr0),
    .dataOut(dout0), .dataValid(val0), .fillCount(cnt0), .isEmpty(emp0), .isFull(full0),
    .isAlmostEmpty(ae0), .isAlmostFull(af0), .overflow(ovf0), .underflow(unf0)
  );

  param_sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT_MODE(1)) u1 (
    .clk(clk), .rstN(rstN), .writeEn(wr1), .dataIn(din1), .readEn(rd1), .clearErr(clr1),
    .dataOut(dout1), .dataValid(val1), .fillCount(cnt1), .isEmpty(emp1), .isFull(full1),
    .isAlmostEmpty(ae1), .isAlmostFull(af1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    wr0 = 0; rd0 = 0; clr0 = 0; din0 = '0;
    wr1 = 0; rd1 = 0; clr1 = 0; din1 = '0;
    #1;
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_empty", 32'(emp0), 1);
    chk("rst_aempty", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_afull", 32'(af0), 0);
    chk("rst_valid", 32'(val0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_unf", 32'(unf0), 0);
    chk("rst_fwft_valid", 32'(val1), 0);
    #12 rstN = 1'b1;

    // Fill eight words
    for (int i = 1; i <= 8; i++) begin
      wr0 = 1; din0 = W'(i);
      step();
      chk("fill_cnt", 32'(cnt0), 32'(i));
      chk("fill_afull", 32'(af0), (i >= 7) ? 1 : 0);
      chk("fill_aempty", 32'(ae0), (i <= 1) ? 1 : 0);
      chk("fill_full", 32'(full0), (i == 8) ? 1 : 0);
    end
    din0 = W'(9);
    step();
    wr0 = 0;
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_cnt", 32'(cnt0), 8);

    // Drain with registered read
    for (int i = 1; i <= 8; i++) begin
      rd0 = 1;
      step();
      chk("pop_valid", 32'(val0), 1);
      chk("pop_data", 32'(dout0), 32'(i));
      chk("pop_cnt", 32'(cnt0), 32'(8 - i));
      rd0 = 0;
      step();
      chk("idle_valid", 32'(val0), 0);
      chk("idle_hold", 32'(dout0), 32'(i));
    end
    chk("no_unf_yet", 32'(unf0), 0);
    rd0 = 1;
    step();
    chk("unf_set", 32'(unf0), 1);
    chk("unf_valid", 32'(val0), 0);
    chk("unf_empty", 32'(emp0), 1);
    clr0 = 1;
    step();
    chk("clr_set_wins_unf", 32'(unf0), 1);
    chk("clr_ovf", 32'(ovf0), 0);
    rd0 = 0;
    step();
    chk("clr_unf", 32'(unf0), 0);
    clr0 = 0;

    // Fill to 4, then 20 cycles of simultaneous push/pop across pointer wrap
    for (int k = 0; k < 4; k++) begin
      wr0 = 1; din0 = W'(32'h100 + k);
      step();
    end
    rd0 = 1;
    for (int c = 0; c < 20; c++) begin
      din0 = W'(32'h104 + c);
      step();
      chk("rw_cnt", 32'(cnt0), 4);
      chk("rw_valid", 32'(val0), 1);
      chk("rw_data", 32'(dout0), 32'(32'h100 + c));
    end
    wr0 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rw_tail", 32'(dout0), 32'(32'h114 + k));
    end
    rd0 = 0;
    step();
    chk("rw_empty", 32'(emp0), 1);

    // Full FIFO with push and pop together: pop wins, push dropped
    for (int k = 0; k < 8; k++) begin
      wr0 = 1; din0 = W'(32'h200 + k);
      step();
    end
    rd0 = 1; din0 = W'(32'h2FF);
    step();
    chk("fullrw_cnt", 32'(cnt0), 7);
    chk("fullrw_ovf", 32'(ovf0), 1);
    chk("fullrw_data", 32'(dout0), 32'h200);
    wr0 = 0; rd0 = 0; clr0 = 1;
    step();
    chk("fullrw_clr", 32'(ovf0), 0);
    clr0 = 0;
    rd0 = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("fullrw_drain", 32'(dout0), 32'(32'h200 + k));
    end
    rd0 = 0;
    step();
    chk("fullrw_empty", 32'(emp0), 1);

    // Empty FIFO with push and pop together: push wins, pop dropped
    wr0 = 1; rd0 = 1; din0 = W'(32'h3AA);
    step();
    wr0 = 0; rd0 = 0;
    chk("emptyrw_cnt", 32'(cnt0), 1);
    chk("emptyrw_unf", 32'(unf0), 1);
    chk("emptyrw_valid", 32'(val0), 0);
    rd0 = 1; clr0 = 1;
    step();
    rd0 = 0; clr0 = 0;
    chk("emptyrw_data", 32'(dout0), 32'h3AA);
    chk("emptyrw_unf_clr", 32'(unf0), 0);

    // FWFT instance
    wr1 = 1; din1 = W'(32'h1ABCD);
    step();
    wr1 = 0;
    chk("fwft_data", 32'(dout1), 32'h1ABCD);
    chk("fwft_valid", 32'(val1), 1);
    step();
    chk("fwft_hold_valid", 32'(val1), 1);
    rd1 = 1;
    step();
    rd1 = 0;
    chk("fwft_pop_valid", 32'(val1), 0);
    chk("fwft_pop_empty", 32'(emp1), 1);
    wr1 = 1; din1 = W'(32'h11);
    step();
    din1 = W'(32'h22);
    step();
    wr1 = 0;
    chk("fwft_head", 32'(dout1), 32'h11);
    rd1 = 1;
    step();
    chk("fwft_next", 32'(dout1), 32'h22);
    chk("fwft_next_valid", 32'(val1), 1);
    step();
    rd1 = 0;
    chk("fwft_drained", 32'(val1), 0);

    // Asynchronous reset mid-operation with a word on the output
    for (int k = 0; k < 6; k++) begin
      wr0 = 1; din0 = W'(32'h400 + k);
      step();
    end
    wr0 = 0; rd0 = 1;
    step();
    rd0 = 0;
    chk("pre_rst_cnt", 32'(cnt0), 5);
    chk("pre_rst_valid", 32'(val0), 1);
    #3 rstN = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt0), 0);
    chk("async_empty", 32'(emp0), 1);
    chk("async_valid", 32'(val0), 0);
    chk("async_dout", 32'(dout0), 0);
    #2 rstN = 1'b1;
    wr0 = 1; din0 = W'(32'h5A5);
    step();
    wr0 = 0;
    chk("post_rst_cnt", 32'(cnt0), 1);
    rd0 = 1;
    step();
    rd0 = 0;
    chk("post_rst_data", 32'(dout0), 32'h5A5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
